param_alu_regfile: RTL and testbench
====================================

Name: param_alu_regfile

Overview:
Parametrised successor to the team's 4-bit ALU. It provides a WIDTH-bit ALU with a DEPTH-entry register file, a persistent flag register, an ADC/CMP/ASR op set and an optional multi-cycle shift-add multiplier. Operations are issued through a valid/ready handshake, and results return with a one-cycle res_valid strobe. It sits behind the tile pin wrapper, which maps pads onto a/b/addr/opcode.

Parameters:
WIDTH, 4, datapath width in bits (>=2)
DEPTH, 8, register file entries (power of two, >=2); AW = clog2(DEPTH)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  tile enable; low = freeze (no accept, state held)
op_valid  in  1  operation request
op_ready  out  1  block can accept an operation this cycle
opcode  in  4  operation select
a  in  WIDTH  operand A / register write data
b  in  WIDTH  operand B / shift amount
addr  in  AW  register file index
res_valid  out  1  one-cycle strobe: result/flags updated
result  out  WIDTH  registered result
flags  out  4  {ZERO, SIGN, OVF, CARRY}, registered

Behaviour:
- Reset (async, rst_n=0): result=0, flags=4'b1000 (ZERO set), res_valid=0, regfile all 0, FSM=IDLE, op_ready=0 while in reset. Reset mid-MUL aborts the multiply, with no result and no write.
- op_ready = ena & (state==IDLE). An operation is accepted on a clock edge with op_valid & op_ready. Inputs are sampled only at acceptance.
- FSM: IDLE -> RUN on accepted MUL; RUN -> IDLE when the bit counter expires. Every other opcode stays in IDLE.
- Single-cycle ops: result, flags and res_valid are visible 1 cycle after the accept edge. Back-to-back accepts every cycle are allowed.
- res_valid is high for exactly one cycle per accepted op, otherwise 0.
- R = regfile[addr] (read of the pre-edge value).
- Opcodes:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL a<<b[clog2(WIDTH)-1:0]
  - 6 SHR logical
  - 7 ASR arithmetic
  - 8 REGWR: regfile[addr]<=a; result<=a; flags unchanged
  - 9 REGRD: result<=R
  - A ADDR a+R
  - B SUBR a-R
  - C ADC a+b+flags.CARRY
  - D CMP: flags from a-b; result unchanged
  - E MUL (see Optional Feature)
  - F reserved: result<=0, flags<=4'b1000
- Arithmetic is computed in WIDTH+1 bits. CARRY = bit WIDTH (SUB/SUBR/CMP: CARRY=1 means no borrow, i.e. a>=b unsigned).
- OVF applies to add-type ops only: operand signs equal and result sign differs. For subtract-type ops: operand signs differ and result sign differs from a. All other ops: OVF=0, CARRY=0.
- ZERO = (result==0). SIGN = result[WIDTH-1]. Both are computed on the new result; for CMP they are computed on the difference.
- A REGWR followed next cycle by REGRD/ADDR at the same addr sees the new value.
- ena low: no accept and no state advance (a RUN multiply pauses). Outputs hold, except res_valid, which drops to 0.

Optional Feature:
Macro ALU_MUL_EN.
- Defined: opcode E is an unsigned shift-add multiply of a*b over WIDTH RUN cycles (one multiplier bit per cycle, 2*WIDTH-bit accumulator). op_ready=0 during RUN. res_valid asserts WIDTH cycles after the accept edge. result = low WIDTH bits; CARRY = |high half; OVF=0; ZERO/SIGN follow result.
- Undefined: opcode E behaves as reserved F in one cycle. No RUN state or accumulator is synthesised.

Test Plan:
- Reset with ops pending -> result=0, flags=1000, res_valid=0, op_ready=0 during reset, 1 after release (ena=1).
- WIDTH=4: ADD 7+1 -> result=8, flags=0110; SUB 3-5 -> result=E, flags=0100; ADC 0+0 right after ADD F+1 -> result=1, flags=0000.
- REGWR a=9 addr=5, next cycle REGRD addr=5 -> result=9; SUBR a=9 addr=5 -> result=0, flags=1001; after reset, REGRD any addr -> 0.
- CMP a=2 b=2 -> flags=1001 and result holds its previous value; ASR a=8 b=1 -> result=C, flags=0100.
- ALU_MUL_EN: MUL 5*3 -> op_ready low for 4 cycles, res_valid exactly 4 cycles after accept, result=F, flags=0100; MUL F*F -> result=1, CARRY=1; rst_n pulse mid-RUN -> IDLE, no res_valid.
- ena=0 mid-MUL for 3 cycles -> counter frozen, completion delayed by 3 cycles, correct product; op_valid held with ena=0 -> no accept, no res_valid.

Source files
------------

// File: rtl/param_alu_regfile.sv
// WIDTH-bit ALU with DEPTH-entry register file, persistent flags and valid/ready issue.
// Optional build macro ALU_MUL_EN adds a multi-cycle unsigned shift-add multiplier on opcode E.
module param_alu_regfile #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    addr,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]        regfile [DEPTH];
  logic [WIDTH-1:0]        r_val;
  logic [WIDTH-1:0]        res_n;
  logic [3:0]              flg_n;
  logic [WIDTH:0]          add_ab, adc_ab, add_ar, sub_ab, sub_ar;
  logic signed [WIDTH-1:0] a_s;
  logic [SW-1:0]           sh;
  logic                    accept;

  // Flag vectors are {ZERO, SIGN, OVF, CARRY}
  function automatic logic [3:0] add_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic [WIDTH:0] s);
    return {(s[WIDTH-1:0] == '0), s[WIDTH-1],
            (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]), s[WIDTH]};
  endfunction

  // CARRY on subtraction is the inverted borrow, so 1 means x >= y unsigned
  function automatic logic [3:0] sub_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic [WIDTH:0] d);
    return {(d[WIDTH-1:0] == '0), d[WIDTH-1],
            (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]), ~d[WIDTH]};
  endfunction

  function automatic logic [3:0] logic_flags(input logic [WIDTH-1:0] r);
    return {(r == '0), r[WIDTH-1], 2'b00};
  endfunction

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc, mcand, acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  assign op_ready = ena & rst_n & (state == IDLE);

  always_comb begin
    acc_nx = acc + (mplier[0] ? mcand : '0);
  end
`else
  assign op_ready = ena & rst_n;
`endif

  assign accept = op_valid & op_ready;

  // issue stage: operand decode and single-cycle result
  always_comb begin
    r_val  = regfile[addr];
    a_s    = a;
    sh     = b[SW-1:0];
    add_ab = {1'b0, a} + {1'b0, b};
    adc_ab = add_ab + {{WIDTH{1'b0}}, flags[0]};
    add_ar = {1'b0, a} + {1'b0, r_val};
    sub_ab = {1'b0, a} - {1'b0, b};
    sub_ar = {1'b0, a} - {1'b0, r_val};
    res_n  = result;
    flg_n  = flags;
    case (opcode)
      4'h0: begin res_n = add_ab[WIDTH-1:0]; flg_n = add_flags(a, b, add_ab); end
      4'h1: begin res_n = sub_ab[WIDTH-1:0]; flg_n = sub_flags(a, b, sub_ab); end
      4'h2: begin res_n = a & b;             flg_n = logic_flags(a & b); end
      4'h3: begin res_n = a | b;             flg_n = logic_flags(a | b); end
      4'h4: begin res_n = a ^ b;             flg_n = logic_flags(a ^ b); end
      4'h5: begin res_n = a << sh;           flg_n = logic_flags(a << sh); end
      4'h6: begin res_n = a >> sh;           flg_n = logic_flags(a >> sh); end
      4'h7: begin res_n = a_s >>> sh;        flg_n = logic_flags(a_s >>> sh); end
      4'h8: begin res_n = a; end
      4'h9: begin res_n = r_val;             flg_n = logic_flags(r_val); end
      4'hA: begin res_n = add_ar[WIDTH-1:0]; flg_n = add_flags(a, r_val, add_ar); end
      4'hB: begin res_n = sub_ar[WIDTH-1:0]; flg_n = sub_flags(a, r_val, sub_ar); end
      4'hC: begin res_n = adc_ab[WIDTH-1:0]; flg_n = add_flags(a, b, adc_ab); end
      4'hD: begin flg_n = sub_flags(a, b, sub_ab); end
      default: begin res_n = '0; flg_n = 4'b1000; end
    endcase
  end

  // result stage: registered outputs, register file and multiplier sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      flags     <= 4'b1000;
      res_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
`ifdef ALU_MUL_EN
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      if (accept) begin
`ifdef ALU_MUL_EN
        if (opcode == 4'hE) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, a};
          mplier <= b;
          cnt    <= CW'(WIDTH - 1);
          state  <= RUN;
        end else
`endif
        begin
          result    <= res_n;
          flags     <= flg_n;
          res_valid <= 1'b1;
          if (opcode == 4'h8) regfile[addr] <= a;
        end
      end
`ifdef ALU_MUL_EN
      else if (ena && state == RUN) begin
        // the last multiplier bit is folded in on the completing edge
        if (cnt == '0) begin
          result    <= acc_nx[WIDTH-1:0];
          flags     <= {(acc_nx[WIDTH-1:0] == '0), acc_nx[WIDTH-1], 1'b0,
                        |acc_nx[2*WIDTH-1:WIDTH]};
          res_valid <= 1'b1;
          state     <= IDLE;
        end else begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_param_alu_regfile.sv
// Directed scoreboard bench for param_alu_regfile at WIDTH=4, DEPTH=8 (both ALU_MUL_EN builds).
module tb_param_alu_regfile;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n, ena, op_valid, op_ready, res_valid;
  logic [3:0] opcode, a, b, result, flags;
  logic [2:0] addr;

  typedef struct {
    string      tag;
    logic [3:0] r;
    logic [3:0] f;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] last_r = 4'h0;

  param_alu_regfile #(.WIDTH(W), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .a(a), .b(b), .addr(addr),
    .res_valid(res_valid), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [3:0] av,
                       input logic [3:0] bv, input logic [2:0] ad,
                       input logic [3:0] er, input logic [3:0] ef, input bit exp_out);
    exp_t e;
    @(negedge clk);
    opcode = op; a = av; b = bv; addr = ad; op_valid = 1'b1;
    if (exp_out) begin
      e.tag = tag; e.r = er; e.f = ef;
      sbq.push_back(e);
      last_r = er;
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  function automatic logic [7:0] add_model(input logic [3:0] x, input logic [3:0] y);
    int s;
    logic [3:0] r;
    s = int'(x) + int'(y);
    r = s[3:0];
    return {r, (r == 4'h0), r[3], (x[3] == y[3]) && (r[3] != x[3]), (s > 15)};
  endfunction

  // Result monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_res_valid", 8'd1, 8'd0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk({e.tag, "_result"}, {4'h0, result}, {4'h0, e.r});
        chk({e.tag, "_flags"}, {4'h0, flags}, {4'h0, e.f});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nrv;
    bit done;
    logic [3:0] ra, rb;
    logic [7:0] m;

    rst_n = 1'b0; ena = 1'b1; op_valid = 1'b1; opcode = 4'h0; a = 4'h7; b = 4'h1; addr = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_result", {4'h0, result}, 8'h00);
    chk("rst_flags", {4'h0, flags}, 8'h08);
    chk("rst_res_valid", {7'h0, res_valid}, 8'h00);
    chk("rst_op_ready", {7'h0, op_ready}, 8'h00);
    op_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {7'h0, op_ready}, 8'h01);
    chk("no_rv_after_reset", {7'h0, res_valid}, 8'h00);

    issue("regrd_reset", 4'h9, 4'h0, 4'h0, 3'd3, 4'h0, 4'b1000, 1);
    issue("add_7_1",     4'h0, 4'h7, 4'h1, 3'd0, 4'h8, 4'b0110, 1);
    issue("sub_3_5",     4'h1, 4'h3, 4'h5, 3'd0, 4'hE, 4'b0100, 1);
    issue("add_f_1",     4'h0, 4'hF, 4'h1, 3'd0, 4'h0, 4'b1001, 1);
    issue("adc_0_0",     4'hC, 4'h0, 4'h0, 3'd0, 4'h1, 4'b0000, 1);
    issue("regwr_9_5",   4'h8, 4'h9, 4'h0, 3'd5, 4'h9, 4'b0000, 1);
    issue("regrd_5",     4'h9, 4'h0, 4'h0, 3'd5, 4'h9, 4'b0100, 1);
    issue("subr_9_5",    4'hB, 4'h9, 4'h0, 3'd5, 4'h0, 4'b1001, 1);
    issue("and_6_3",     4'h2, 4'h6, 4'h3, 3'd0, 4'h2, 4'b0000, 1);
    issue("cmp_2_2",     4'hD, 4'h2, 4'h2, 3'd0, 4'h2, 4'b1001, 1);
    issue("asr_8_1",     4'h7, 4'h8, 4'h1, 3'd0, 4'hC, 4'b0100, 1);
    issue("or_5_a",      4'h3, 4'h5, 4'hA, 3'd0, 4'hF, 4'b0100, 1);
    issue("xor_f_f",     4'h4, 4'hF, 4'hF, 3'd0, 4'h0, 4'b1000, 1);
    issue("shl_3_2",     4'h5, 4'h3, 4'h2, 3'd0, 4'hC, 4'b0100, 1);
    issue("shr_8_3",     4'h6, 4'h8, 4'h3, 3'd0, 4'h1, 4'b0000, 1);
    issue("shl_amt_mask",4'h5, 4'h1, 4'h6, 3'd0, 4'h4, 4'b0000, 1);
    issue("addr_1_5",    4'hA, 4'h1, 4'h0, 3'd5, 4'hA, 4'b0100, 1);
    issue("sub_ovf_8_1", 4'h1, 4'h8, 4'h1, 3'd0, 4'h7, 4'b0011, 1);
    issue("reserved_f",  4'hF, 4'h5, 4'h5, 3'd0, 4'h0, 4'b1000, 1);
    issue("cmp_3_5",     4'hD, 4'h3, 4'h5, 3'd0, 4'h0, 4'b0100, 1);
`ifndef ALU_MUL_EN
    issue("op_e_reserved", 4'hE, 4'h5, 4'h3, 3'd0, 4'h0, 4'b1000, 1);
`endif
    for (int i = 0; i < 8; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      m = add_model(ra, rb);
      issue($sformatf("add_rand%0d", i), 4'h0, ra, rb, 3'd0, m[7:4], m[3:0], 1);
    end

    // ena low with a request held: nothing accepted, outputs hold
    @(negedge clk);
    ena = 1'b0; op_valid = 1'b1; opcode = 4'h0; a = 4'h1; b = 4'h1;
    repeat (3) begin
      @(negedge clk);
      chk("ena0_ready", {7'h0, op_ready}, 8'h00);
      chk("ena0_rv", {7'h0, res_valid}, 8'h00);
      chk("ena0_hold", {4'h0, result}, {4'h0, last_r});
    end
    op_valid = 1'b0; ena = 1'b1;

`ifdef ALU_MUL_EN
    issue("mul_5_3", 4'hE, 4'h5, 4'h3, 3'd0, 4'hF, 4'b0100, 1);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("mul_run_ready", {7'h0, op_ready}, 8'h00);
      chk("mul_run_rv", {7'h0, res_valid}, 8'h00);
    end
    @(negedge clk);
    chk("mul_done_rv", {7'h0, res_valid}, 8'h01);
    chk("mul_done_ready", {7'h0, op_ready}, 8'h01);

    issue("mul_f_f", 4'hE, 4'hF, 4'hF, 3'd0, 4'h1, 4'b0001, 1);
    repeat (W + 1) @(negedge clk);

    issue("mul_7_3_frozen", 4'hE, 4'h7, 4'h3, 3'd0, 4'h5, 4'b0001, 1);
    @(negedge clk);
    ena = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("mul_frozen_rv", {7'h0, res_valid}, 8'h00);
    end
    ena = 1'b1;
    cyc = 3; done = 1'b0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      done = res_valid;
    end
    chk("mul_frozen_latency", 8'(cyc), 8'(W + 3));

    issue("mul_abort", 4'hE, 4'h6, 4'h7, 3'd0, 4'h0, 4'h0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", {4'h0, result}, 8'h00);
    chk("abort_flags", {4'h0, flags}, 8'h08);
    chk("abort_ready", {7'h0, op_ready}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (res_valid) nrv++;
    end
    chk("abort_no_rv", 8'(nrv), 8'h00);
    chk("abort_idle_ready", {7'h0, op_ready}, 8'h01);
`else
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("pulse_result", {4'h0, result}, 8'h00);
    chk("pulse_ready", {7'h0, op_ready}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    issue("regrd_5_after_reset", 4'h9, 4'h0, 4'h0, 3'd5, 4'h0, 4'b1000, 1);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 8'(sbq.size()), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
